// File: rtl/id_ex_pipe_pkg.sv
// Shared types for the ID->EX pipeline register: occupancy encoding of the
// {main_valid, skid_valid} pair that forms the implicit FSM.
package id_ex_pipe_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'b00,
      OCC_ILLEGAL = 2'b01,
      OCC_ONE     = 2'b10,
      OCC_FULL    = 2'b11
   } occ_e;

   function automatic occ_e occ_of(input logic main_valid, input logic skid_valid);
      return occ_e'({main_valid, skid_valid});
   endfunction

endpackage

// File: rtl/id_ex_pipe_slot.sv
// One pipeline slot: valid flag plus payload register with load, clear and
// asynchronous reset. Clear wins over load so a flush always empties the slot.
module id_ex_pipe_slot
   import id_ex_pipe_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clr) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush, bubble-masked control and a saturating stall counter.
module id_ex_pipe
   import id_ex_pipe_pkg::*;
#(
   parameter int DATA_W  = 160,
   parameter int CTRL_W  = 24,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   localparam int PW = DATA_W + CTRL_W;

   logic          main_valid, skid_valid;
   logic [PW-1:0] main_q, skid_q, main_d, in_pay;
   logic          main_load, main_clr, skid_load, skid_clr;
   logic          in_hs, out_hs;
   occ_e          occ;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign in_pay = {in_data, in_ctrl};
   assign occ    = occ_of(main_valid, skid_valid);

   // With the skid buffer, in_ready comes straight from a flop (no path from out_ready).
   assign in_ready = (SKID_EN != 0) ? !skid_valid : (!main_valid | out_ready);
   assign in_hs    = in_valid & in_ready;
   assign out_hs   = main_valid & out_ready;

   always_comb begin
      main_load = 1'b0;
      main_clr  = flush;
      skid_load = 1'b0;
      skid_clr  = flush;
      main_d    = in_pay;
      if (SKID_EN == 0) begin
         main_load = in_hs;
         main_clr  = flush | (out_hs & !in_hs);
      end else begin
         case (occ)
            OCC_EMPTY: main_load = in_hs;
            OCC_ONE: begin
               main_load = in_hs & out_hs;
               skid_load = in_hs & !out_hs;
               main_clr  = flush | (out_hs & !in_hs);
            end
            OCC_FULL: begin
               // Older skid entry advances first, preserving FIFO order.
               main_d    = skid_q;
               main_load = out_hs;
               skid_clr  = flush | out_hs;
            end
            default: ;
         endcase
      end
   end

   id_ex_pipe_slot #(.W(PW)) u_main (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .load  (main_load),
      .clr   (main_clr),
      .d     (main_d),
      .valid (main_valid),
      .q     (main_q)
   );

   generate
      if (SKID_EN != 0) begin : g_skid
         id_ex_pipe_slot #(.W(PW)) u_skid (
            .clk   (sys_clk),
            .rst   (sys_rst),
            .load  (skid_load),
            .clr   (skid_clr),
            .d     (in_pay),
            .valid (skid_valid),
            .q     (skid_q)
         );
      end else begin : g_noskid
         assign skid_valid = 1'b0;
         assign skid_q     = '0;
      end
   endgenerate

   assign out_valid = main_valid;
   assign out_data  = main_q[PW-1 -: DATA_W];
   assign out_ctrl  = main_q[CTRL_W-1:0] & {CTRL_W{main_valid}};

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         stall_cnt <= '0;
      else if (stall_clr)
         stall_cnt <= '0;
      else if (main_valid & !out_ready)
         stall_cnt <= sat_inc(stall_cnt);
   end

   illegal_occ: assert property (@(posedge sys_clk) disable iff (sys_rst) occ != OCC_ILLEGAL);

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: a skid instance (CNT_W=4) and a combinational-ready
// instance share stimulus; each is tracked by a queue-based reference model.
module tb_id_ex_pipe;

   localparam int DW = 160;
   localparam int CW = 24;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic          in_valid, flush, out_ready, stall_clr;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;

   logic          a_in_ready, a_out_valid;
   logic [DW-1:0] a_out_data;
   logic [CW-1:0] a_out_ctrl;
   logic [3:0]    a_stall;
   logic          b_in_ready, b_out_valid;
   logic [DW-1:0] b_out_data;
   logic [CW-1:0] b_out_ctrl;
   logic [15:0]   b_stall;

   always #5 sys_clk = ~sys_clk;

   id_ex_pipe #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .CNT_W(4)) u_a (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
      .stall_cnt(a_stall), .stall_clr(stall_clr));

   id_ex_pipe #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0), .CNT_W(16)) u_b (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
      .stall_cnt(b_stall), .stall_clr(stall_clr));

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } item_t;

   item_t qa[$];
   item_t qb[$];
   int    cnt_a, cnt_b;
   bit    ma_ov, ma_ir, ma_ihs, ma_ohs;
   bit    mb_ov, mb_ir, mb_ihs, mb_ohs;
   int    n_cmp, n_bad;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Compare both DUTs with the models away from the clock edge.
   task automatic sample();
      logic [CW-1:0] ec;
      @(negedge sys_clk);
      ma_ov  = qa.size() > 0;
      ma_ir  = qa.size() < 2;
      mb_ov  = qb.size() > 0;
      mb_ir  = (qb.size() == 0) || out_ready;
      ma_ihs = in_valid && ma_ir;
      ma_ohs = ma_ov && out_ready;
      mb_ihs = in_valid && mb_ir;
      mb_ohs = mb_ov && out_ready;
      chk("a_in_ready", DW'(a_in_ready), DW'(ma_ir));
      chk("a_out_valid", DW'(a_out_valid), DW'(ma_ov));
      ec = '0;
      if (ma_ov) ec = qa[0].c;
      chk("a_out_ctrl", DW'(a_out_ctrl), DW'(ec));
      if (ma_ov) chk("a_out_data", a_out_data, qa[0].d);
      chk("a_stall_cnt", DW'(a_stall), DW'(cnt_a));
      chk("b_in_ready", DW'(b_in_ready), DW'(mb_ir));
      chk("b_out_valid", DW'(b_out_valid), DW'(mb_ov));
      ec = '0;
      if (mb_ov) ec = qb[0].c;
      chk("b_out_ctrl", DW'(b_out_ctrl), DW'(ec));
      if (mb_ov) chk("b_out_data", b_out_data, qb[0].d);
      chk("b_stall_cnt", DW'(b_stall), DW'(cnt_b));
   endtask

   task automatic model_reset();
      qa.delete();
      qb.delete();
      cnt_a = 0;
      cnt_b = 0;
   endtask

   task automatic advance();
      @(posedge sys_clk);
      if (sys_rst) begin
         model_reset();
      end else begin
         if (flush) begin
            qa.delete();
            qb.delete();
         end else begin
            if (ma_ohs) void'(qa.pop_front());
            if (ma_ihs) qa.push_back(item_t'{d: in_data, c: in_ctrl});
            if (mb_ohs) void'(qb.pop_front());
            if (mb_ihs) qb.push_back(item_t'{d: in_data, c: in_ctrl});
         end
         if (stall_clr) cnt_a = 0;
         else if (ma_ov && !out_ready) cnt_a = (cnt_a + 1 > 15) ? 15 : cnt_a + 1;
         if (stall_clr) cnt_b = 0;
         else if (mb_ov && !out_ready) cnt_b = (cnt_b + 1 > 65535) ? 65535 : cnt_b + 1;
      end
      #1;
   endtask

   typedef struct {
      bit            iv;
      bit            orr;
      bit            fl;
      logic [CW-1:0] c;
      bit            e_ov;
      logic [CW-1:0] e_c;
      bit            e_ir;
      int            e_st;
   } vec_t;

   vec_t tbl[18];
   int   idx, b_outs;

   initial begin
      // Back-pressure, flush in FULL, flush over an accepted input, flush with output handshake.
      tbl[0]  = '{1, 0, 0, 1,  0, 0,  1, 0};
      tbl[1]  = '{1, 0, 0, 2,  1, 1,  1, 0};
      tbl[2]  = '{1, 0, 0, 3,  1, 1,  0, 1};
      tbl[3]  = '{1, 0, 0, 3,  1, 1,  0, 2};
      tbl[4]  = '{1, 1, 0, 3,  1, 1,  0, 3};
      tbl[5]  = '{1, 1, 0, 3,  1, 2,  1, 3};
      tbl[6]  = '{0, 1, 0, 0,  1, 3,  1, 3};
      tbl[7]  = '{0, 1, 0, 0,  0, 0,  1, 3};
      tbl[8]  = '{1, 0, 0, 4,  0, 0,  1, 3};
      tbl[9]  = '{1, 0, 0, 5,  1, 4,  1, 3};
      tbl[10] = '{1, 0, 1, 6,  1, 4,  0, 4};
      tbl[11] = '{1, 1, 0, 7,  0, 0,  1, 5};
      tbl[12] = '{0, 1, 0, 0,  1, 7,  1, 5};
      tbl[13] = '{1, 0, 0, 8,  0, 0,  1, 5};
      tbl[14] = '{1, 0, 1, 9,  1, 8,  1, 5};
      tbl[15] = '{1, 1, 0, 10, 0, 0,  1, 6};
      tbl[16] = '{0, 1, 1, 0,  1, 10, 1, 6};
      tbl[17] = '{0, 0, 0, 0,  0, 0,  1, 6};

      n_cmp = 0;
      n_bad = 0;
      model_reset();

      // Reset with in_valid held high.
      sys_rst   = 1'b1;
      in_valid  = 1'b1;
      in_data   = DW'(8'hA5);
      in_ctrl   = 24'h00005A;
      flush     = 1'b0;
      out_ready = 1'b0;
      stall_clr = 1'b0;
      repeat (2) begin
         sample();
         chk("rst_a_out_data", a_out_data, '0);
         chk("rst_b_out_data", b_out_data, '0);
         advance();
      end
      sys_rst = 1'b0;
      sample();
      advance();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sample();
      chk("first_load_valid", DW'(a_out_valid), DW'(1'b1));
      chk("first_load_data", a_out_data, DW'(8'hA5));
      advance();

      // Streaming, 8 back-to-back with out_ready=1.
      for (int i = 1; i <= 9; i++) begin
         in_valid = (i <= 8);
         in_ctrl  = CW'(i);
         in_data  = DW'(i) + DW'(32'h100);
         sample();
         if (i > 1) chk("stream_ctrl", DW'(a_out_ctrl), DW'(i - 1));
         if (i > 1) chk("stream_b_ctrl", DW'(b_out_ctrl), DW'(i - 1));
         advance();
      end
      in_valid  = 1'b0;
      stall_clr = 1'b1;
      sample();
      advance();
      stall_clr = 1'b0;

      // Table-driven corner sequences on the skid instance.
      for (int i = 0; i < 18; i++) begin
         in_valid  = tbl[i].iv;
         in_ctrl   = tbl[i].c;
         in_data   = DW'(tbl[i].c) + DW'(32'h1000);
         out_ready = tbl[i].orr;
         flush     = tbl[i].fl;
         sample();
         chk($sformatf("tbl%0d_out_valid", i), DW'(a_out_valid), DW'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_out_ctrl", i), DW'(a_out_ctrl), DW'(tbl[i].e_c));
         chk($sformatf("tbl%0d_in_ready", i), DW'(a_in_ready), DW'(tbl[i].e_ir));
         chk($sformatf("tbl%0d_stall", i), DW'(a_stall), DW'(tbl[i].e_st));
         if (tbl[i].e_ov)
            chk($sformatf("tbl%0d_out_data", i), a_out_data, DW'(tbl[i].e_c) + DW'(32'h1000));
         advance();
      end
      flush = 1'b0;

      // Combinational-ready instance with out_ready toggling; source holds until accepted.
      idx    = 1;
      b_outs = 0;
      for (int k = 0; k < 44; k++) begin
         out_ready = (k % 2 == 0) || (k >= 40);
         in_valid  = (idx <= 16);
         in_ctrl   = CW'(idx + 32'h40);
         in_data   = DW'(idx);
         sample();
         if (mb_ov) chk("comb_ready_tracks", DW'(b_in_ready), DW'(out_ready));
         if (mb_ihs) idx++;
         if (mb_ohs) b_outs++;
         advance();
      end
      chk("comb_all_accepted", DW'(idx), DW'(17));
      chk("comb_all_delivered", DW'(b_outs), DW'(16));

      // Saturation of the 4-bit counter and clear priority.
      in_valid  = 1'b0;
      out_ready = 1'b1;
      stall_clr = 1'b1;
      sample();
      advance();
      stall_clr = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 24'h77;
      in_data   = DW'(32'h77);
      out_ready = 1'b0;
      sample();
      advance();
      in_valid = 1'b0;
      repeat (20) begin
         sample();
         advance();
      end
      sample();
      chk("sat_cnt", DW'(a_stall), DW'(15));
      advance();
      stall_clr = 1'b1;
      sample();
      advance();
      stall_clr = 1'b0;
      sample();
      chk("clr_wins", DW'(a_stall), DW'(0));
      advance();

      // Asynchronous reset in the middle of a cycle clears everything at once.
      #2;
      sys_rst = 1'b1;
      #1;
      chk("async_rst_a_valid", DW'(a_out_valid), DW'(0));
      chk("async_rst_a_ctrl", DW'(a_out_ctrl), DW'(0));
      chk("async_rst_a_data", a_out_data, '0);
      chk("async_rst_a_ready", DW'(a_in_ready), DW'(1));
      chk("async_rst_a_stall", DW'(a_stall), DW'(0));
      chk("async_rst_b_valid", DW'(b_out_valid), DW'(0));
      model_reset();
      sample();
      advance();
      sys_rst = 1'b0;

      // Randomized traffic against the reference models.
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         stall_clr = ($urandom_range(0, 29) == 0);
         in_ctrl   = CW'($urandom);
         in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
         sample();
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID→EX pipeline register with a valid/ready handshake, an optional two-entry skid buffer, a synchronous flush for control hazards, and a saturating stall counter. It sits between decode and the EXU. The payload is split into two parts:
- **Data:** operands, pc+4 and store data.
- **Control:** wb_select, is_write_dmem, alu_op and the like; control bits are forced to zero whenever the output is a bubble.

Back-pressure and flushes are handled in one block, so decode and EX never need ad-hoc stall muxes.

## Interface
Parameters:
- DATA_W, 160, data payload width (final_a, final_b, pc_plus_4, dmem_write_data, concatenated by the instantiator).
- CTRL_W, 24, control payload width (rd, wb_select, write_width, alu_op, sub, slt flags, word_op, is_write_dmem, pc_sel).
- SKID_EN, 1, selects the buffering mode:
  - 1: two-entry skid buffer with registered in_ready.
  - 0: single register with combinational in_ready.
- CNT_W, 16, stall counter width.

Ports:
- sys_clk  in  1  single clock; all state changes on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents a valid instruction.
- in_ready  out  1  block accepts the input this cycle.
- in_data  in  DATA_W  decode data payload.
- in_ctrl  in  CTRL_W  decode control payload.
- flush  in  1  kill all held and incoming instructions (branch/jump redirect).
- out_valid  out  1  EX stage has a valid instruction.
- out_ready  in  1  EX consumes the output this cycle.
- out_data  out  DATA_W  data payload to EX.
- out_ctrl  out  CTRL_W  control payload to EX; all zero when out_valid=0.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.
- stall_clr  in  1  synchronous clear of stall_cnt.

## Operation
- **Handshakes.** An input handshake is in_valid&in_ready; an output handshake is out_valid&out_ready.
- **Storage, SKID_EN=1.** Two slots, main (drives the outputs) and skid; in_ready = !skid_valid, taken from a register.
  - EMPTY (main and skid invalid):
    - input handshake → ONE, input loaded into main.
  - ONE (main valid, skid invalid):
    - output handshake with no input → EMPTY.
    - output handshake and input handshake → ONE, main reloaded from the input.
    - input with no output handshake → FULL, input loaded into skid.
    - otherwise hold.
  - FULL (both valid; in_ready=0):
    - output handshake → ONE, skid moved into main, skid invalidated.
    - otherwise hold.
- **Storage, SKID_EN=0.**
  - Main only; in_ready = !out_valid | out_ready (combinational).
  - Main loads on an input handshake; otherwise main clears on an output handshake.
- **Flush.** Synchronous and highest priority. On the flush edge:
  - All valids are cleared and an input handshake in the same cycle is dropped.
  - The next cycle shows out_valid=0 and in_ready=1.
- **Bubble masking.**
  - out_ctrl = main_ctrl & {CTRL_W{main_valid}}.
  - out_data holds its last loaded value and is don't-care when invalid.
- **Stall counter.**
  - Increments when out_valid & !out_ready.
  - Saturates at all ones (no wrap).
  - stall_clr has priority over increment; the counter is not affected by flush.
- **Ordering.** Strict FIFO: an instruction in skid is never overtaken by one arriving later.
- No payload transformation; widths pass through unchanged.

## Timing
- **Reset values.**
  - Async assert: main_valid=0, skid_valid=0, out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
  - in_ready=1 during and after reset.
- **Latency.** 1 cycle from input handshake to out_valid when EMPTY, or when ONE with out_ready=1.
- **Throughput.** 1 instruction/cycle sustained while out_ready=1.
- **Back-pressure.**
  - SKID_EN=1: in_ready falls the cycle after FULL is entered; no input-side combinational path from out_ready.
  - SKID_EN=0: the out_ready→in_ready combinational path is permitted.
- **Reset mid-operation.** Reset asserted mid-operation drops all contents immediately. Deassertion is sampled synchronously by the flops' reset synchroniser upstream; nothing in this block assumes otherwise.
- **Flush and handshake in the same cycle.** Flush in the same cycle as an output handshake: the handshake still counts for the consumer, and the state after the edge is EMPTY.

## Structure
- Field-width macros (XLEN, CTRL field widths) live in the shared para.v include. The instantiator packs and unpacks in_data/in_ctrl using those macros.
- One sub-module, pipe_slot: a valid+payload register with load, clear and async reset, instantiated once for main and once for skid. Skid is generated only when SKID_EN=1.
- The FSM is implicit in {main_valid, skid_valid}. The encoding 2'b01 (skid valid, main invalid) is illegal; an assertion checks for it.

## Test plan
- Reset with in_valid=1 held → out_valid=0, out_ctrl=0, stall_cnt=0, in_ready=1. The first rising edge after deassert loads in_data=0xA5 and out_valid=1 one cycle later.
- Streaming: 8 back-to-back inputs (ctrl=1..8) with out_ready=1 → outputs 1..8 on consecutive cycles, never stalled.
- Back-pressure, SKID_EN=1: out_ready=0 while inputs 1, 2, 3 are offered.
  - After the edge that loads 1: main=1. After the edge that loads 2: FULL, with in_ready=0 on the next cycle. Input 3 is held by the source.
  - Release → outputs 1, 2, 3 in order; stall_cnt equals the number of held cycles.
- Flush in FULL state with a simultaneous in_valid=1 → next cycle out_valid=0, out_ctrl=0, in_ready=1; none of the held or incoming instructions ever appear.
- SKID_EN=0 with out_ready toggling 1,0,1,0 → in_ready tracks out_ready in the same cycle while valid; no loss or duplication over 16 inputs.
- Counter: CNT_W=4, hold a stall for 20 cycles → stall_cnt=15 (saturated). stall_clr → 0 next cycle, even while the stall continues (clr wins).
